// File: rtl/renode_apb4_requester_queue.sv
// -----------------------------------------------------------------------------
// renode_apb4_requester_queue
//
// APB4 requester with a request queue and completion buffering. Requests are
// accepted on a valid/ready channel into a QueueDepth-entry FIFO and issued on
// APB4 one at a time. Back-to-back transfers do not need an idle cycle. Each
// completion goes into a 2-entry response FIFO whose head drives the rsp_*
// outputs. An ACCESS phase that waits TimeoutCycles cycles without pready is
// aborted and reported as error+timeout.
//
// Ports
//   pclk, presetn          clock; synchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_write/addr/wdata/strb/prot   request payload
//   rsp_valid/rsp_ready    completion handshake
//   rsp_rdata/error/timeout/write    completion payload (head of response FIFO)
//   paddr/psel/penable/pwrite/pwdata/pstrb/pprot   APB4 requester outputs
//   pready/prdata/pslverr  APB4 completer inputs
// -----------------------------------------------------------------------------
module renode_apb4_requester_queue #(
   parameter int unsigned AddressWidth  = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned QueueDepth    = 4,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic                      pclk,
   input  logic                      presetn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [AddressWidth-1:0]   req_addr,
   input  logic [DataWidth-1:0]      req_wdata,
   input  logic [DataWidth/8-1:0]    req_strb,
   input  logic [2:0]                req_prot,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DataWidth-1:0]      rsp_rdata,
   output logic                      rsp_error,
   output logic                      rsp_timeout,
   output logic                      rsp_write,
   output logic [AddressWidth-1:0]   paddr,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [DataWidth-1:0]      pwdata,
   output logic [DataWidth/8-1:0]    pstrb,
   output logic [2:0]                pprot,
   input  logic                      pready,
   input  logic [DataWidth-1:0]      prdata,
   input  logic                      pslverr
);

   localparam int unsigned StrbW = DataWidth / 8;
   localparam int unsigned PtrW  = $clog2(QueueDepth);
   localparam int unsigned CntW  = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_e;

   typedef struct packed {
      logic                    write;
      logic [AddressWidth-1:0] addr;
      logic [DataWidth-1:0]    wdata;
      logic [StrbW-1:0]        strb;
      logic [2:0]              prot;
   } req_t;

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic                 error;
      logic                 timeout;
      logic                 write;
   } rsp_t;

   state_e state_q, state_d;

   // ---------------------------------------------------------------------------
   // Request FIFO (extra pointer bit distinguishes full from empty)
   // ---------------------------------------------------------------------------
   req_t          req_mem_q [QueueDepth];
   logic [PtrW:0] req_wr_q, req_wr_d;
   logic [PtrW:0] req_rd_q, req_rd_d;
   logic          req_full;
   logic          req_empty;
   logic          req_push;
   logic          req_pop;
   req_t          req_in;
   req_t          req_head;

   assign req_full  = (req_wr_q[PtrW] != req_rd_q[PtrW]) &&
                      (req_wr_q[PtrW-1:0] == req_rd_q[PtrW-1:0]);
   assign req_empty = (req_wr_q == req_rd_q);
   assign req_ready = presetn && !req_full;
   assign req_push  = req_valid && req_ready;
   assign req_head  = req_mem_q[req_rd_q[PtrW-1:0]];

   always_comb begin
      req_in       = '0;
      req_in.write = req_write;
      req_in.addr  = req_addr;
      req_in.wdata = req_wdata;
      req_in.strb  = req_strb;
      req_in.prot  = req_prot;
   end

   always_comb begin
      req_wr_d = req_wr_q;
      req_rd_d = req_rd_q;
      if (req_push) req_wr_d = req_wr_q + (PtrW+1)'(1);
      if (req_pop)  req_rd_d = req_rd_q + (PtrW+1)'(1);
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         req_wr_q <= '0;
         req_rd_q <= '0;
      end else begin
         req_wr_q <= req_wr_d;
         req_rd_q <= req_rd_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (req_push) req_mem_q[req_wr_q[PtrW-1:0]] <= req_in;
   end

   // ---------------------------------------------------------------------------
   // Response FIFO (2 entries)
   // ---------------------------------------------------------------------------
   rsp_t       rsp_mem_q [2];
   logic       rsp_wr_q, rsp_wr_d;
   logic       rsp_rd_q, rsp_rd_d;
   logic [1:0] rsp_cnt_q, rsp_cnt_d;
   logic       rsp_push;
   logic       rsp_pop;
   rsp_t       rsp_in;
   rsp_t       rsp_head;
   logic [1:0] rsp_cnt_after_pop;
   logic       room_idle;
   logic       room_cmpl;

   assign rsp_valid   = (rsp_cnt_q != 2'd0);
   assign rsp_pop     = rsp_valid && rsp_ready;
   assign rsp_head    = rsp_mem_q[rsp_rd_q];
   assign rsp_rdata   = rsp_head.rdata;
   assign rsp_error   = rsp_head.error;
   assign rsp_timeout = rsp_head.timeout;
   assign rsp_write   = rsp_head.write;

   // A new transfer may only start if the response FIFO will hold at most one
   // entry once this edge's pop (and, on completion, this edge's push) land, so
   // the eventual completion always finds a free slot.
   assign rsp_cnt_after_pop = rsp_cnt_q - {1'b0, rsp_pop};
   assign room_idle         = (rsp_cnt_after_pop <= 2'd1);
   assign room_cmpl         = (rsp_cnt_after_pop == 2'd0);

   always_comb begin
      rsp_wr_d  = rsp_wr_q;
      rsp_rd_d  = rsp_rd_q;
      rsp_cnt_d = rsp_cnt_q;
      if (rsp_push) rsp_wr_d = ~rsp_wr_q;
      if (rsp_pop)  rsp_rd_d = ~rsp_rd_q;
      if (rsp_push && !rsp_pop)      rsp_cnt_d = rsp_cnt_q + 2'd1;
      else if (!rsp_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - 2'd1;
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         rsp_wr_q  <= 1'b0;
         rsp_rd_q  <= 1'b0;
         rsp_cnt_q <= 2'd0;
      end else begin
         rsp_wr_q  <= rsp_wr_d;
         rsp_rd_q  <= rsp_rd_d;
         rsp_cnt_q <= rsp_cnt_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (rsp_push) rsp_mem_q[rsp_wr_q] <= rsp_in;
   end

   // ---------------------------------------------------------------------------
   // Transfer FSM, ACCESS-cycle counter and registered APB outputs
   // ---------------------------------------------------------------------------
   logic [CntW-1:0]         tmo_q, tmo_d;
   logic                    tmo_hit;
   logic                    psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [AddressWidth-1:0] paddr_q, paddr_d;
   logic [DataWidth-1:0]    pwdata_q, pwdata_d;
   logic [StrbW-1:0]        pstrb_q, pstrb_d;
   logic [2:0]              pprot_q, pprot_d;

   assign tmo_hit = (TimeoutCycles != 0) && (tmo_q == CntW'(TimeoutCycles));

   always_comb begin
      state_d  = state_q;
      req_pop  = 1'b0;
      rsp_push = 1'b0;
      rsp_in   = '0;
      tmo_d    = tmo_q;

      unique case (state_q)
         S_IDLE: begin
            if (!req_empty && room_idle) state_d = S_SETUP;
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            req_pop = 1'b1;
            tmo_d   = CntW'(1);
         end
         S_ACCESS: begin
            if (pready) begin
               rsp_push      = 1'b1;
               rsp_in.rdata  = pwrite_q ? '0 : prdata;
               rsp_in.error  = pslverr;
               rsp_in.write  = pwrite_q;
               state_d       = (!req_empty && room_cmpl) ? S_SETUP : S_IDLE;
            end else if (tmo_hit) begin
               rsp_push       = 1'b1;
               rsp_in.error   = 1'b1;
               rsp_in.timeout = 1'b1;
               rsp_in.write   = pwrite_q;
               state_d        = S_IDLE;
            end else if (TimeoutCycles != 0) begin
               tmo_d = tmo_q + CntW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_SETUP) tmo_d = '0;
   end

   // APB outputs are registered from the next state. Entering SETUP loads the
   // current FIFO head (the previous request was already popped on its own
   // SETUP->ACCESS edge), ACCESS holds, IDLE clears.
   always_comb begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
      pstrb_d   = '0;
      pprot_d   = '0;
      unique case (state_d)
         S_SETUP: begin
            psel_d   = 1'b1;
            pwrite_d = req_head.write;
            paddr_d  = req_head.addr;
            pwdata_d = req_head.write ? req_head.wdata : '0;
            pstrb_d  = req_head.write ? req_head.strb  : '0;
            pprot_d  = req_head.prot;
         end
         S_ACCESS: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            pwrite_d  = pwrite_q;
            paddr_d   = paddr_q;
            pwdata_d  = pwdata_q;
            pstrb_d   = pstrb_q;
            pprot_d   = pprot_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         tmo_q     <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         pprot_q   <= '0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         pprot_q   <= pprot_d;
      end
   end

   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;
   assign pstrb   = pstrb_q;
   assign pprot   = pprot_q;

endmodule

// File: tb/tb_renode_apb4_requester_queue.sv
// -----------------------------------------------------------------------------
// tb_renode_apb4_requester_queue
//
// Directed bench for renode_apb4_requester_queue (TimeoutCycles = 4). The
// completer returns prdata = {paddr[15:0], paddr[31:16]}. Expected responses
// are queued when a request is accepted; a negedge monitor pops and compares
// every completion handshake. Stimulus also checks APB timing directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_renode_apb4_requester_queue;

   logic        pclk      = 1'b0;
   logic        presetn   = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr  = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_strb  = '0;
   logic [2:0]  req_prot  = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        rsp_timeout;
   logic        rsp_write;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready  = 1'b1;
   logic [31:0] prdata;
   logic        pslverr = 1'b0;

   assign prdata = {paddr[15:0], paddr[31:16]};

   renode_apb4_requester_queue #(
      .AddressWidth  (32),
      .DataWidth     (32),
      .QueueDepth    (4),
      .TimeoutCycles (4)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_strb    (req_strb),
      .req_prot    (req_prot),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_error   (rsp_error),
      .rsp_timeout (rsp_timeout),
      .rsp_write   (rsp_write),
      .paddr       (paddr),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pprot       (pprot),
      .pready      (pready),
      .prdata      (prdata),
      .pslverr     (pslverr)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        timeout;
      logic        write;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   xfers = 0;

   always @(posedge pclk) begin
      if (presetn && psel && penable && pready) xfers <= xfers + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge pclk) begin
      exp_t e;
      if (presetn && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b to=%0b wr=%0b expected none",
                     rsp_rdata, rsp_error, rsp_timeout, rsp_write);
         end else begin
            e = sb.pop_front();
            chk("rsp", {rsp_rdata, rsp_error, rsp_timeout, rsp_write}, e);
         end
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       input logic expect_rsp, input exp_t e);
      bit acc = 1'b0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_strb  = s;
      req_prot  = p;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = req_ready;
         tick();
      end
      req_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_accept: got no acceptance expected req_ready within 50 cycles");
      end else if (expect_rsp) begin
         sb.push_back(e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expected test end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bp_rdata [4];
      int          base;
      bp_rdata[0] = 32'h0010_0000;
      bp_rdata[1] = 32'h0014_0000;
      bp_rdata[2] = 32'h0018_0000;
      bp_rdata[3] = 32'h001C_0000;

      // Reset
      presetn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_ctl", {psel, penable, pwrite, pstrb, pprot, rsp_valid, req_ready}, 64'd0);
         chk("reset_data", {paddr, pwdata}, 64'd0);
      end
      presetn = 1'b1;
      tick();
      chk("ready_after_reset", req_ready, 64'd1);

      // Single write, zero-wait
      send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b1, {32'h0, 1'b0, 1'b0, 1'b1});
      chk("wr_idle_k", psel, 64'd0);
      tick();
      chk("wr_setup", {psel, penable, pwrite, pprot}, {1'b1, 1'b0, 1'b1, 3'b010});
      chk("wr_paddr", paddr, 64'h1004);
      tick();
      chk("wr_access", {psel, penable, rsp_valid}, 3'b110);
      chk("wr_pwdata", {pwdata, pstrb}, {32'hDEAD_BEEF, 4'hF});
      tick();
      chk("wr_rsp_k3", {rsp_valid, psel}, 2'b10);
      tick();

      // Single read, zero-wait
      send(1'b0, 32'h5678_1234, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b1, {32'h1234_5678, 1'b0, 1'b0, 1'b0});
      tick();
      chk("rd_setup", {psel, penable, pwrite}, 3'b100);
      tick();
      chk("rd_wdata_zero", {pwdata, pstrb}, 64'd0);
      tick();
      chk("rd_rsp_k3", rsp_valid, 64'd1);
      tick();

      // Four queued writes, back-to-back
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(1'b1, 32'h0000_0100 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 4'h3, 3'b001,
                    1'b1, {32'h0, 1'b0, 1'b0, 1'b1});
         end
         begin
            @(posedge pclk);
            #1;
            for (int i = 1; i <= 8; i++) begin
               tick();
               chk("b2b_psel", psel, 64'd1);
               chk("b2b_penable", penable, (i % 2 == 0) ? 64'd1 : 64'd0);
               if (i % 2 == 1) chk("b2b_paddr", paddr, 64'h100 + 64'(4 * ((i - 1) / 2)));
            end
            chk("b2b_no_rsp_k8", rsp_valid, 64'd0);
            tick();
            chk("b2b_last_rsp_k9", {rsp_valid, psel}, 2'b10);
         end
      join
      tick();

      // Back-pressure
      rsp_ready = 1'b0;
      base      = xfers;
      for (int i = 0; i < 4; i++)
         send(1'b0, 32'h0000_0010 + 32'(4 * i), 32'h0, 4'h0, 3'b000, 1'b1,
              {bp_rdata[i], 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 6; i++) tick();
      chk("bp_two_xfers", xfers - base, 64'd2);
      chk("bp_idle", {psel, rsp_valid, req_ready}, 3'b011);
      rsp_ready = 1'b1;
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      chk("bp_all_xfers", xfers - base, 64'd4);
      tick();

      // Timeout: pready held low
      pready = 1'b0;
      send(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b111, 1'b1, {32'h0, 1'b1, 1'b1, 1'b0});
      tick();
      chk("to_setup", {psel, penable, pprot}, {1'b1, 1'b0, 3'b111});
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk("to_wait", {psel, penable, rsp_valid}, 3'b110);
      end
      tick();
      chk("to_abort", {psel, penable, rsp_valid, rsp_timeout}, 4'b0011);
      tick();

      // pready in the timeout cycle completes normally
      send(1'b1, 32'h0000_0080, 32'h5555_AAAA, 4'b0101, 3'b000, 1'b1, {32'h0, 1'b0, 1'b0, 1'b1});
      for (int i = 0; i < 5; i++) tick();
      chk("tob_access", {psel, penable, rsp_valid}, 3'b110);
      pready = 1'b1;
      tick();
      chk("tob_complete", {psel, rsp_valid, rsp_timeout, rsp_error}, 4'b0100);
      tick();

      // PSLVERR
      pslverr = 1'b1;
      send(1'b1, 32'h0000_00C0, 32'h0000_0001, 4'h1, 3'b000, 1'b1, {32'h0, 1'b1, 1'b0, 1'b1});
      tick();
      tick();
      tick();
      chk("slverr_rsp", {rsp_valid, rsp_error, rsp_timeout}, 3'b110);
      pslverr = 1'b0;
      tick();

      // Reset during a wait state with a second request queued
      pready = 1'b0;
      send(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b000, 1'b0, '0);
      send(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3'b000, 1'b0, '0);
      tick();
      chk("rst_mid_access", {psel, penable}, 2'b11);
      presetn = 1'b0;
      tick();
      chk("rst_mid_drop", {psel, penable, rsp_valid, req_ready}, 4'b0000);
      presetn = 1'b1;
      pready  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rst_queue_empty", {psel, rsp_valid}, 2'b00);
      end

      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("sb_drained", sb.size(), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/renode_apb4_requester_queue.md
# renode_apb4_requester_queue

Synthesizable APB4 requester core that accepts bus requests on a valid/ready request channel, queues them, and issues them on an APB4 bus. Back-to-back transfers need no idle cycle. Completions are returned on a valid/ready response channel with error and timeout status. It sits between a co-simulation or bus-bridge front end and any APB3/APB4 completer. It adds four things to the single-transfer APB3 requester: a request queue, PSTRB/PPROT, completion buffering, and a wait-state timeout.

## Interface
Parameters:
- AddressWidth, 32, width of PADDR and req_addr.
- DataWidth, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- QueueDepth, 4, request FIFO entries; power of two, at least 2.
- TimeoutCycles, 256, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports (clock and reset first):
- pclk  input  1  single clock for everything.
- presetn  input  1  reset: synchronous, active-low.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid and req_ready are both high on a pclk edge.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  AddressWidth  target address.
- req_wdata  input  DataWidth  write data.
- req_strb  input  DataWidth/8  write byte strobes.
- req_prot  input  3  protection attributes.
- rsp_valid  output  1  completion valid.
- rsp_ready  input  1  completion accepted.
- rsp_rdata  output  DataWidth  read data; 0 for writes and timeouts.
- rsp_error  output  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- rsp_write  output  1  echo of the request's req_write.
- paddr  output  AddressWidth  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  DataWidth  APB write data.
- pstrb  output  DataWidth/8  APB strobes.
- pprot  output  3  APB protection.
- pready  input  1  completer ready.
- prdata  input  DataWidth  completer read data.
- pslverr  input  1  completer error.

## Operation
- Request FIFO has QueueDepth entries. req_ready = presetn && !full.
- Response FIFO has 2 entries. rsp_* outputs show its head entry.
- FSM states are S_IDLE, S_SETUP and S_ACCESS.
- S_IDLE -> S_SETUP when the request FIFO is non-empty and the response FIFO holds at most 1 entry after this edge, counting a pop at this edge. Otherwise stay in S_IDLE.
- S_SETUP -> S_ACCESS unconditionally. The head request is popped on this edge.
- S_ACCESS, pready=1: the transfer completes.
  - A response is pushed: rdata = prdata for reads and 0 for writes; error = pslverr; timeout = 0.
  - Next state is S_SETUP if the request FIFO is non-empty and the response room rule still holds. Otherwise next state is S_IDLE.
- S_ACCESS, pready=0, when TimeoutCycles != 0 and this is ACCESS cycle number TimeoutCycles: abort.
  - A response is pushed with rdata = 0, error = 1, timeout = 1.
  - Next state is S_IDLE.
- S_ACCESS, pready=0 otherwise: stay in S_ACCESS.
- The SETUP entry rule guarantees the response FIFO has room at every completion. The completer is never stalled by the requester.
- APB outputs in S_SETUP and S_ACCESS come from the request being issued:
  - paddr, pwrite and pprot follow the request.
  - pwdata and pstrb are the request values for writes and 0 for reads.
  - psel = 1.
  - penable = 1 in S_ACCESS only.
- In S_IDLE every APB output is 0.
- All APB outputs are registered and stable for the whole transfer.
- Unaligned addresses are passed through unchanged; no check is made.

## Timing
- Reset, presetn=0 at an edge:
  - state = S_IDLE; both FIFOs are emptied; the ACCESS counter is cleared.
  - psel, penable, pwrite, paddr, pwdata, pstrb and pprot = 0.
  - rsp_valid = 0 and req_ready = 0.
- Reset mid-transfer drops psel/penable at that edge. The in-flight transfer and all queued transfers are discarded with no response.
- Latency with an empty queue, request accepted at edge k:
  - psel = 1 from edge k+1.
  - penable = 1 from edge k+2.
  - with pready = 1 in that cycle, rsp_valid = 1 from edge k+3.
- Back-to-back transfers: psel stays high between transfers and penable drops for exactly one SETUP cycle, so each zero-wait transfer takes 2 cycles.
- Simultaneous push and pop on a full request FIFO are not possible, because req_ready is low when full. Simultaneous push and pop on the response FIFO keep its occupancy unchanged.
- Timeout counter: it is 1 in the first ACCESS cycle and resets on entry to S_SETUP. The abort edge is the edge at the end of ACCESS cycle TimeoutCycles.
- pready=1 in the timeout cycle counts as a normal completion.
- Pointers wrap modulo QueueDepth. Full/empty status is tracked with an extra pointer bit.

## Test plan
- Reset to idle: hold presetn=0 for 3 cycles, then release.
  -> All outputs are 0 during reset; req_ready=1 one cycle after release.
- Single transfers, zero-wait completer:
  - write 0x0000_1004 / 0xDEADBEEF / strb 0xF -> psel at k+1, penable at k+2, PWDATA=0xDEADBEEF, response with error=0.
  - read returning 0x1234_5678 -> rsp_rdata=0x12345678.
- Four queued writes with rsp_ready=1:
  - psel stays high across all transfers and penable toggles.
  - Last response arrives at k+9.
- Back-pressure: rsp_ready=0 while 4 requests are queued.
  - Exactly 2 transfers complete, then the FSM idles with psel=0.
  - Raising rsp_ready resumes transfers; responses keep request order.
- Timeout with TimeoutCycles=4 and pready held low:
  - Abort after 4 ACCESS cycles.
  - Response is error=1, timeout=1, rdata=0; psel=0 the next cycle.
- PSLVERR plus reset mid-ACCESS:
  - pslverr=1 with pready=1 -> error=1, timeout=0.
  - presetn=0 during a wait-state -> psel=0 at that edge, no response, queue empty.
